// File: rtl/game_pkg.sv
// Shared types and constants for the minesweeper game controller.
// Holds FSM encodings, LFSR tap mask and the mine map width.
package game_pkg;

    localparam int MAP_W = 64;

    // Fibonacci taps 16,14,13,11 as bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [6:0] CNT_MAX = 7'd64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GEN  = 3'd1,
        S_LOAD = 3'd2,
        S_PLAY = 3'd3,
        S_WON  = 3'd4,
        S_LOST = 3'd5
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running after reset.
// The seed is loaded synchronously while reset is high.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    // Shift left, feedback is the XOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= seed;
        end else begin
            out <= {out[14:0], ^(out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game controller: mine map generation, key edge detection and
// play-phase strobes toward the board datapath.
module game_controller
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          DENSITY_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_key,
    input  logic             flag_key,
    input  logic             move_right,
    input  logic             move_left,
    input  logic             win,
    input  logic             lose,
    output logic             clr_maps,
    output logic             ld_mm,
    output logic             ld_fm,
    output logic             ld_sm,
    output logic [MAP_W-1:0] mm_out,
    output logic [1:0]       dir,
    output logic [2:0]       state,
    output logic [6:0]       steps,
    output logic [6:0]       flags
);

    localparam logic [15:0] DMASK = 16'((1 << DENSITY_BITS) - 1);

    state_t      st;
    state_t      st_n;
    logic [15:0] lfsr;
    logic        mine;
    logic        armed;
    logic        start_q, step_q, flag_q;
    logic        start_p, step_p, flag_p;
    logic        first_q;
    logic [5:0]  gen_cnt;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .out   (lfsr)
    );

    // A mine needs all density bits set; other bits are forced high.
    assign mine  = &(lfsr | ~DMASK);
    assign state = st;

    // Registered key edges; armed blocks a pulse from a key held over reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b0;
            start_q <= 1'b0;
            step_q  <= 1'b0;
            flag_q  <= 1'b0;
            start_p <= 1'b0;
            step_p  <= 1'b0;
            flag_p  <= 1'b0;
        end else begin
            armed   <= 1'b1;
            start_q <= start;
            step_q  <= step_key;
            flag_q  <= flag_key;
            start_p <= armed & start & ~start_q;
            step_p  <= armed & step_key & ~step_q;
            flag_p  <= armed & flag_key & ~flag_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_IDLE;
        end else begin
            st <= st_n;
        end
    end

    // Next state and strobes; strobes are killed while reset is high.
    always_comb begin
        st_n     = st;
        clr_maps = 1'b0;
        ld_mm    = 1'b0;
        ld_fm    = 1'b0;
        ld_sm    = 1'b0;
        unique case (st)
            S_IDLE, S_WON, S_LOST: begin
                if (start_p) begin
                    st_n     = S_GEN;
                    clr_maps = 1'b1;
                end
            end
            S_GEN: begin
                if (gen_cnt == 6'd63) st_n = S_LOAD;
            end
            S_LOAD: begin
                ld_mm = 1'b1;
                st_n  = S_PLAY;
            end
            S_PLAY: begin
                if (start_p) begin
                    st_n     = S_GEN;
                    clr_maps = 1'b1;
                end else begin
                    if (step_p)      ld_sm = 1'b1;
                    else if (flag_p) ld_fm = 1'b1;
                    if (!first_q) begin
                        if (lose)     st_n = S_LOST;
                        else if (win) st_n = S_WON;
                    end
                end
            end
            default: st_n = S_IDLE;
        endcase
        if (reset) begin
            clr_maps = 1'b0;
            ld_mm    = 1'b0;
            ld_fm    = 1'b0;
            ld_sm    = 1'b0;
        end
    end

    // Map shift, counters and registered direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            mm_out  <= '0;
            steps   <= '0;
            flags   <= '0;
            dir     <= 2'b00;
            gen_cnt <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= (st == S_LOAD);
            if (st_n == S_PLAY)
                dir <= {move_left & ~move_right, move_right & ~move_left};
            else
                dir <= 2'b00;
            if (st == S_GEN) begin
                gen_cnt <= gen_cnt + 6'd1;
                mm_out  <= {mine, mm_out[MAP_W-1:2],
                            (gen_cnt == 6'd63) ? 1'b0 : mm_out[1]};
            end
            if (st == S_LOAD) begin
                steps <= '0;
                flags <= '0;
            end
            if (ld_sm && steps != CNT_MAX) steps <= steps + 7'd1;
            if (ld_fm && flags != CNT_MAX) flags <= flags + 7'd1;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
// Strobes are matched against a queue of expected load events.
module tb_game_controller;

    logic        clk = 1'b0;
    logic        reset, start, step_key, flag_key;
    logic        move_right, move_left, win, lose;
    logic        clr_maps, ld_mm, ld_fm, ld_sm;
    logic [63:0] mm_out;
    logic [1:0]  dir;
    logic [2:0]  state;
    logic [6:0]  steps, flags;

    int chk = 0;
    int err = 0;
    int exp_q[$];
    logic [15:0] lfsr_m;
    logic [63:0] mm1, mm2, mm3;

    game_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .step_key   (step_key),
        .flag_key   (flag_key),
        .move_right (move_right),
        .move_left  (move_left),
        .win        (win),
        .lose       (lose),
        .clr_maps   (clr_maps),
        .ld_mm      (ld_mm),
        .ld_fm      (ld_fm),
        .ld_sm      (ld_sm),
        .mm_out     (mm_out),
        .dir        (dir),
        .state      (state),
        .steps      (steps),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    // Reference LFSR, taps 16,14,13,11.
    always @(posedge clk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else lfsr_m <= {lfsr_m[14:0],
                        lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every load strobe must match the next queued expectation.
    always @(negedge clk) begin
        int obs;
        int exp;
        obs = ld_mm ? 1 : ld_fm ? 2 : ld_sm ? 3 : 0;
        if (obs != 0) begin
            exp = (exp_q.size() == 0) ? 0 : exp_q.pop_front();
            check("strobe", 64'(obs), 64'(exp));
            check("onehot", 64'($countones({ld_mm, ld_fm, ld_sm})), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic f);
        step_key = s;
        flag_key = f;
        tick();
        tick();
        step_key = 1'b0;
        flag_key = 1'b0;
        tick();
    endtask

    task automatic play_game(output logic [63:0] seen);
        logic [63:0] exp;
        exp = '0;
        start = 1'b1;
        tick();
        check("clr_maps", 64'(clr_maps), 64'd1);
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            check("gen_state", 64'(state), 64'd1);
            exp = {&lfsr_m[2:0], exp[63:1]};
        end
        exp[0] = 1'b0;
        exp_q.push_back(1);
        tick();
        check("load_state", 64'(state), 64'd2);
        check("ld_mm", 64'(ld_mm), 64'd1);
        check("mm_out", mm_out, exp);
        tick();
        check("play_state", 64'(state), 64'd3);
        check("mm0", 64'(mm_out[0]), 64'd0);
        check("steps_clr", 64'(steps), 64'd0);
        check("flags_clr", 64'(flags), 64'd0);
        seen = mm_out;
    endtask

    initial begin
        reset = 1'b1;
        {start, step_key, flag_key} = 3'b000;
        {move_right, move_left, win, lose} = 4'b0000;
        tick();
        tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_mm", mm_out, 64'd0);
        check("rst_steps", 64'(steps), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_clr", 64'(clr_maps), 64'd0);
        reset = 1'b0;
        tick();
        move_right = 1'b1;
        tick();
        tick();
        check("dir_idle", 64'(dir), 64'd0);
        move_right = 1'b0;

        play_game(mm1);
        exp_q.push_back(3);
        press(1'b1, 1'b1);
        check("steps_both", 64'(steps), 64'd1);
        check("flags_both", 64'(flags), 64'd0);
        exp_q.push_back(2);
        press(1'b0, 1'b1);
        check("flags_one", 64'(flags), 64'd1);
        for (int i = 0; i < 70; i++) begin
            exp_q.push_back(3);
            press(1'b1, 1'b0);
        end
        check("steps_sat", 64'(steps), 64'd64);

        move_right = 1'b1;
        tick();
        tick();
        check("dir_right", 64'(dir), 64'd1);
        move_left = 1'b1;
        tick();
        check("dir_both", 64'(dir), 64'd0);
        move_right = 1'b0;
        tick();
        check("dir_left", 64'(dir), 64'd2);
        move_left = 1'b0;
        move_right = 1'b1;
        tick();

        lose = 1'b1;
        win = 1'b1;
        tick();
        check("lost_state", 64'(state), 64'd5);
        check("dir_lost", 64'(dir), 64'd0);
        lose = 1'b0;
        win = 1'b0;
        press(1'b1, 1'b0);
        check("lost_steps", 64'(steps), 64'd64);
        check("lost_hold", 64'(state), 64'd5);
        move_right = 1'b0;

        play_game(mm2);
        check("mm_differs", 64'(mm2 != mm1), 64'd1);
        win = 1'b1;
        tick();
        check("win_masked", 64'(state), 64'd3);
        tick();
        check("won_state", 64'(state), 64'd4);
        win = 1'b0;
        press(1'b1, 1'b0);
        check("won_steps", 64'(steps), 64'd0);

        start = 1'b1;
        tick();
        check("clr_won", 64'(clr_maps), 64'd1);
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        check("rst_gen", 64'(state), 64'd0);
        check("rst_gen_mm", mm_out, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        check("idle_stay", 64'(state), 64'd0);

        start = 1'b1;
        step_key = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("held_clr", 64'(clr_maps), 64'd0);
        tick();
        check("held_state", 64'(state), 64'd0);
        start = 1'b0;
        step_key = 1'b0;
        tick();

        play_game(mm3);
        start = 1'b1;
        tick();
        check("clr_abort", 64'(clr_maps), 64'd1);
        start = 1'b0;
        tick();
        check("abort_gen", 64'(state), 64'd1);
        start = 1'b1;
        tick();
        tick();
        check("gen_no_clr", 64'(clr_maps), 64'd0);
        start = 1'b0;
        tick();
        check("gen_ignore", 64'(state), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
